sum_monitor: RTL

//  Downstream checker for the dual-counter sum output q. Samples q every enabled cycle and

---
 rtl/sum_monitor_if.sv | 39 +++
 rtl/sum_monitor.sv | 117 +++++++++++
 2 files changed

// File: rtl/sum_monitor_if.sv
// Sum-monitor bus: the q sample stream plus the monitor's registered status.
// Parameters: SIZE (q width), WRAP_CNT_W (wrap counter width).
// Signals: en, q (and clr when SUM_MONITOR_CLEAR_EN is defined) flow toward the
// monitor; state, locked, err, bad_q, last_q, wrap_cnt flow back from it.
// Modports: master = stimulus/observer side, slave = the monitor itself.
interface sum_monitor_if #(
  parameter int unsigned SIZE       = 10,
  parameter int unsigned WRAP_CNT_W = 8
);
  logic                  en;
`ifdef SUM_MONITOR_CLEAR_EN
  logic                  clr;
`endif
  logic [SIZE-1:0]       q;
  logic [1:0]            state;
  logic                  locked;
  logic                  err;
  logic [SIZE-1:0]       bad_q;
  logic [SIZE-1:0]       last_q;
  logic [WRAP_CNT_W-1:0] wrap_cnt;

  modport master (
    output en,
`ifdef SUM_MONITOR_CLEAR_EN
    output clr,
`endif
    output q,
    input  state, locked, err, bad_q, last_q, wrap_cnt
  );

  modport slave (
    input  en,
`ifdef SUM_MONITOR_CLEAR_EN
    input  clr,
`endif
    input  q,
    output state, locked, err, bad_q, last_q, wrap_cnt
  );
endinterface

// File: rtl/sum_monitor.sv
// sum_monitor: checks that every enabled sample of q equals the previous
// accepted sample plus STEP (mod 2^SIZE). Counts clean wrap-arounds in a
// saturating counter and latches the first bad sample into a sticky fault.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - sum_monitor_if.slave: en/q (and clr) in; state, locked, err,
//          bad_q, last_q, wrap_cnt out (all registered)
// Optional feature macro: SUM_MONITOR_CLEAR_EN adds bus.clr, which returns
// the monitor to IDLE and clears err/bad_q while keeping last_q/wrap_cnt.
module sum_monitor #(
  parameter int unsigned SIZE       = 10,
  parameter int unsigned STEP       = 2,
  parameter int unsigned WRAP_CNT_W = 8
) (
  input logic            clk,
  input logic            rst,
  sum_monitor_if.slave   bus
);

  // STEP wider than q is reduced modulo 2^SIZE.
  localparam logic [SIZE-1:0] STEP_W = SIZE'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  err_q, err_d;
  logic [SIZE-1:0]       bad_q_q, bad_q_d;
  logic [SIZE-1:0]       last_q_q, last_q_d;
  logic [WRAP_CNT_W-1:0] wrap_q, wrap_d;
  logic                  locked_q;
  logic [SIZE-1:0]       exp_q;

  assign exp_q = last_q_q + STEP_W;

  // Next-state and next-register values.
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    bad_q_d  = bad_q_q;
    last_q_d = last_q_q;
    wrap_d   = wrap_q;

    case (state_q)
      IDLE: begin
        // First sample only primes the reference; nothing to compare yet.
        if (bus.en) begin
          last_q_d = bus.q;
          state_d  = TRACK;
        end
      end
      TRACK: begin
        if (bus.en) begin
          if (bus.q == exp_q) begin
            last_q_d = bus.q;
            // A correct sample below the reference means the sum wrapped.
            if ((bus.q < last_q_q) && (wrap_q != '1)) begin
              wrap_d = wrap_q + WRAP_CNT_W'(1);
            end
          end else begin
            state_d = FAULT;
            err_d   = 1'b1;
            bad_q_d = bus.q;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef SUM_MONITOR_CLEAR_EN
    // Clear re-arms from any state; history (last_q, wrap_cnt) survives.
    if (bus.clr) begin
      state_d  = IDLE;
      err_d    = 1'b0;
      bad_q_d  = '0;
      last_q_d = last_q_q;
      wrap_d   = wrap_q;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      bad_q_q  <= '0;
      last_q_q <= '0;
      wrap_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      bad_q_q  <= bad_q_d;
      last_q_q <= last_q_d;
      wrap_q   <= wrap_d;
      locked_q <= (state_d == TRACK);
    end
  end

  assign bus.state    = state_q;
  assign bus.locked   = locked_q;
  assign bus.err      = err_q;
  assign bus.bad_q    = bad_q_q;
  assign bus.last_q   = last_q_q;
  assign bus.wrap_cnt = wrap_q;

endmodule
